// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared state encoding and field widths for the tone sequencer.
package tone_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
    localparam int BEATS_W = 4;
    localparam int CNT_W = 24;
    localparam logic [BEATS_W-1:0] END_MARK = '0;
endpackage

// File: rtl/tone_seq_if.sv
// tone_seq_if: control, table-write and playback signals of the tone sequencer.
interface tone_seq_if #(parameter int WIDTH = 16, parameter int NOTES = 16);
    import tone_seq_pkg::*;
    localparam int AW = $clog2(NOTES);
    logic lrclk;
    logic start;
    logic stop;
    logic loop;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [WIDTH-1:0] wr_period;
    logic [BEATS_W-1:0] wr_beats;
    logic [WIDTH-1:0] period;
    logic gate;
    logic busy;
    logic [AW-1:0] step;
    logic done;
    modport master (
        output lrclk, start, stop, loop, wr_en, wr_addr, wr_period, wr_beats,
        input period, gate, busy, step, done
    );
    modport slave (
        input lrclk, start, stop, loop, wr_en, wr_addr, wr_period, wr_beats,
        output period, gate, busy, step, done
    );
endinterface

// File: rtl/tone_seq_ram.sv
// tone_seq_ram: note table, one write port and one read port with one-cycle latency.
module tone_seq_ram
    import tone_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NOTES = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(NOTES)-1:0]      wa,
    input  logic [WIDTH+BEATS_W-1:0]      wd,
    input  logic [$clog2(NOTES)-1:0]      ra,
    output logic [WIDTH+BEATS_W-1:0]      rd
);
    logic [WIDTH+BEATS_W-1:0] mem [NOTES];

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a note table, driving period/gate timed by lrclk sample ticks.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int NOTES          = 16,
    parameter int TICKS_PER_BEAT = 4800,
    parameter int GAP_TICKS      = 480
) (
    input logic       clk,
    input logic       reset,
    tone_seq_if.slave bus
);
    localparam int AW = $clog2(NOTES);

    if (NOTES < 2 || (NOTES & (NOTES - 1)) != 0) begin : g_chk_notes
        $error("NOTES must be a power of two");
    end
    if (GAP_TICKS >= TICKS_PER_BEAT) begin : g_chk_gap
        $error("GAP_TICKS must be less than TICKS_PER_BEAT");
    end
    if (((1 << BEATS_W) - 1) * TICKS_PER_BEAT >= (1 << CNT_W)) begin : g_chk_cnt
        $error("max beats * TICKS_PER_BEAT overflows the tick counter");
    end

    state_t state, state_n;
    logic [AW-1:0] step, step_n;
    logic [CNT_W-1:0] cnt, cnt_n, load_cnt;
    logic [WIDTH-1:0] period, period_n, rd_period;
    logic [BEATS_W-1:0] rd_beats;
    logic [WIDTH+BEATS_W-1:0] rd_word;
    logic gate, gate_n, done, done_n, lrclk_d, tick, busy, last_tick;

    // Read address is the next step so the entry is ready during the single LOAD cycle.
    tone_seq_ram #(.WIDTH(WIDTH), .NOTES(NOTES)) u_ram (
        .clk (clk),
        .we  (bus.wr_en),
        .wa  (bus.wr_addr),
        .wd  ({bus.wr_period, bus.wr_beats}),
        .ra  (step_n),
        .rd  (rd_word)
    );

    assign rd_period = rd_word[WIDTH+BEATS_W-1:BEATS_W];
    assign rd_beats  = rd_word[BEATS_W-1:0];
    assign busy      = state != IDLE;
    assign tick      = bus.lrclk & ~lrclk_d;
    assign last_tick = tick && cnt == CNT_W'(1);
    assign load_cnt  = CNT_W'(rd_beats) * CNT_W'(TICKS_PER_BEAT) - CNT_W'(GAP_TICKS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            cnt     <= '0;
            period  <= '0;
            gate    <= 1'b0;
            done    <= 1'b0;
            lrclk_d <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            cnt     <= cnt_n;
            period  <= period_n;
            gate    <= gate_n;
            done    <= done_n;
            lrclk_d <= bus.lrclk;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        cnt_n    = cnt;
        period_n = period;
        gate_n   = gate;
        done_n   = 1'b0;
        if (busy && bus.stop) begin
            state_n = IDLE;
            gate_n  = 1'b0;
            done_n  = 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.stop) begin
                    state_n = LOAD;
                    step_n  = '0;
                end
                LOAD: if (rd_beats == END_MARK) begin
                    // A marker at index 0 always ends playback so an empty table cannot spin.
                    if (bus.loop && step != '0) step_n = '0;
                    else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        gate_n  = 1'b0;
                    end
                end else begin
                    state_n  = PLAY;
                    period_n = rd_period;
                    gate_n   = rd_period != '0;
                    cnt_n    = load_cnt;
                end
                PLAY: if (tick) begin
                    cnt_n = cnt - 1'b1;
                    if (last_tick) begin
                        state_n = GAP;
                        gate_n  = 1'b0;
                        cnt_n   = CNT_W'(GAP_TICKS);
                    end
                end
                GAP: if (tick) begin
                    cnt_n = cnt - 1'b1;
                    if (last_tick) begin
                        if (step == AW'(NOTES - 1) && !bus.loop) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = LOAD;
                            step_n  = step + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.period = period;
    assign bus.gate   = gate;
    assign bus.busy   = busy;
    assign bus.step   = step;
    assign bus.done   = done;
endmodule
